skid_arbiter: RTL and testbench
===============================

# skid_arbiter

Round-robin arbiter that merges NUM_PORTS valid/ready request streams into the single input of the downstream skid buffer. The skid buffer input has no ready signal, so this block keeps an exact shadow of the buffer's occupancy and grants only while space remains. With that rule the buffer's overflow flag never asserts. The block sits directly upstream of the skid buffer and shares the buffer's clock.

## Interface
- NUM_PORTS, 4: number of requesters, at least 2.
- DATA_SIZE, 16: payload width. Must match the skid buffer.
- FIFO_DEPTH, 5: skid buffer depth. Must match the skid buffer.

- clk  in  1  single clock shared with the skid buffer.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  NUM_PORTS  per-port request valid.
- in_data  in  NUM_PORTS*DATA_SIZE  per-port payload; port i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- in_ready  out  NUM_PORTS  one-hot grant. Port i transfers when in_valid[i] & in_ready[i].
- in_last  in  NUM_PORTS  last beat of a packet. Present only with SKID_ARB_LOCK_EN.
- buf_valid  out  1  drives the skid buffer's in_valid.
- buf_data  out  DATA_SIZE  drives the skid buffer's in_data.
- buf_ready  in  1  the same out_ready that the consumer applies to the skid buffer.
- occupancy  out  $clog2(FIFO_DEPTH+1)  shadow count of entries held in the buffer.

## Operation
- Shadow count `size` mirrors the buffer exactly:
  - send & buf_ready: no change. This covers bypass when the buffer is empty and shift-through when it is full.
  - send only: +1.
  - buf_ready & size>0 & !send: -1.
  - buf_ready & size==0 & !send: stays 0.
- space = (size < FIFO_DEPTH). It deliberately excludes buf_ready, so there is no combinational path from buf_ready to in_ready.
- Grant: with space=1, pick the first port with in_valid set, searching from `ptr` upward with wrap at NUM_PORTS. Drive in_ready one-hot on that port. With space=0, in_ready = 0.
- buf_valid = |(in_valid & in_ready). buf_data is the granted port's in_data.
- Pointer: after a transfer from port g, ptr <= (g+1) mod NUM_PORTS. With no transfer, ptr holds.
- Invariant: size <= FIFO_DEPTH always. buf_valid never asserts while size == FIFO_DEPTH.

## Timing
- Grant is combinational, same cycle as in_valid, from registered ptr and size. Zero-cycle arbitration latency.
- size and ptr update on the clk edge after the transfer.
- Throughput is one beat per cycle while size < FIFO_DEPTH. When full, grants resume the cycle after any buf_ready drain.
- A requester may drop in_valid without a grant. Payload must be stable only in the transfer cycle.
- Reset, including mid-operation: size=0, ptr=0, state IDLE. Outputs in reset: in_ready=0, buf_valid=0, occupancy=0.
- The skid buffer has no reset. The system must guarantee the buffer is empty when rst_n deasserts, by holding buf_ready high for at least FIFO_DEPTH cycles of reset.

## Configuration
- SKID_ARB_LOCK_EN defined: adds the in_last port and a two-state FSM.
  - IDLE: grants round-robin as above.
  - A transfer with in_last=0 moves to LOCKED on the granted port. ptr does not advance.
  - LOCKED: only the locked port may receive in_ready, still gated by space.
  - A transfer with in_last=1 returns to IDLE and sets ptr = locked+1.
  - Reset forces IDLE.
- SKID_ARB_LOCK_EN undefined: no in_last port and no FSM. Every beat is independently arbitrated.

## Structure
- Package skid_arb_pkg holds:
  - the state enum {IDLE, LOCKED};
  - a localparam function for pointer width, $clog2(NUM_PORTS);
  - the shared count-width helper $clog2(FIFO_DEPTH+1).
- Sub-module rr_pick: purely combinational. Inputs are the request vector and ptr; outputs are the one-hot grant and the encoded index. The shadow count, pointer and FSM stay in skid_arbiter.

## Test plan
- All 4 ports valid, buf_ready=1 constantly, FIFO_DEPTH=5 -> grants 0,1,2,3,0… one per cycle; occupancy stays 0.
- All ports valid, buf_ready=0 -> exactly 5 grants, then in_ready=0 with occupancy=5. One buf_ready pulse -> occupancy 4, and one grant the following cycle.
- Pair with the real skid buffer under random in_valid/buf_ready for 10k cycles -> overflow never asserts; occupancy equals the buffer's size every cycle; output order matches grant order.
- Only port 2 valid, ptr=3 -> wraps to grant port 2; next ptr=3.
- LOCK_EN: port 1 sends a 3-beat packet while port 0 is valid -> port 0 is not granted until after port 1's in_last beat; then ptr=2.
- rst_n low mid-packet with occupancy=3 -> next cycle occupancy=0, in_ready=0, FSM IDLE, ptr=0.

Source files
------------

// File: rtl/skid_arb_pkg.sv
// Shared types and width helpers for the skid-buffer round-robin arbiter.
package skid_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int ptr_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  function automatic int cnt_width(input int fifo_depth);
    return $clog2(fifo_depth + 1);
  endfunction

endpackage

// File: rtl/skid_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import skid_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic found;
  int   port;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    port  = 0;
    for (int i = 0; i < N; i++) begin
      port = (int'(ptr) + i) % N;
      if (!found && req[port]) begin
        found       = 1'b1;
        grant[port] = 1'b1;
        idx         = PW'(port);
      end
    end
  end

endmodule

// File: rtl/skid_arbiter.sv
// Round-robin arbiter feeding a ready-less skid buffer, gated by a shadow occupancy count.
// Optional packet locking via `SKID_ARB_LOCK_EN (adds in_last and an IDLE/LOCKED FSM).
module skid_arbiter
  import skid_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_SIZE  = 16,
  parameter int FIFO_DEPTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] in_data,
  output logic [NUM_PORTS-1:0]           in_ready,
`ifdef SKID_ARB_LOCK_EN
  input  logic [NUM_PORTS-1:0]           in_last,
`endif
  output logic                           buf_valid,
  output logic [DATA_SIZE-1:0]           buf_data,
  input  logic                           buf_ready,
  output logic [cnt_width(FIFO_DEPTH)-1:0] occupancy
);

  localparam int PW = ptr_width(NUM_PORTS);
  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [CW-1:0]        size_q, size_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] pick_grant;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        next_ptr;
  logic                 space;
  logic                 send;

`ifdef SKID_ARB_LOCK_EN
  arb_state_e           state_q, state_d;
  logic [PW-1:0]        lock_q, lock_d;
`endif

  rr_pick #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // space ignores buf_ready on purpose so in_ready never depends on it combinationally
  always_comb begin
    space = (size_q < CW'(FIFO_DEPTH));
    req   = in_valid;
`ifdef SKID_ARB_LOCK_EN
    if (state_q == LOCKED) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (PW'(i) != lock_q) req[i] = 1'b0;
      end
    end
`endif
    in_ready  = (space && rst_n) ? pick_grant : '0;
    send      = |(in_valid & in_ready);
    buf_valid = send;
    buf_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_ready[i]) buf_data = in_data[i*DATA_SIZE +: DATA_SIZE];
    end
    occupancy = size_q;
  end

  always_comb begin
    size_d   = size_q;
    ptr_d    = ptr_q;
    next_ptr = (pick_idx == PW'(NUM_PORTS - 1)) ? '0 : pick_idx + PW'(1);
    if (send && !buf_ready) begin
      size_d = size_q + CW'(1);
    end else if (!send && buf_ready && (size_q != '0)) begin
      size_d = size_q - CW'(1);
    end
`ifdef SKID_ARB_LOCK_EN
    state_d = state_q;
    lock_d  = lock_q;
    if (send) begin
      if (in_last[pick_idx]) begin
        state_d = IDLE;
        ptr_d   = next_ptr;
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        lock_d  = pick_idx;
      end
    end
`else
    if (send) ptr_d = next_ptr;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q  <= '0;
      ptr_q   <= '0;
`ifdef SKID_ARB_LOCK_EN
      state_q <= IDLE;
      lock_q  <= '0;
`endif
    end else begin
      size_q  <= size_d;
      ptr_q   <= ptr_d;
`ifdef SKID_ARB_LOCK_EN
      state_q <= state_d;
      lock_q  <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_skid_arbiter.sv
// Directed bench for skid_arbiter; lock checks build only with `SKID_ARB_LOCK_EN.
module tb_skid_arbiter;

  localparam int NumPorts  = 4;
  localparam int DataSize  = 16;
  localparam int FifoDepth = 5;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NumPorts-1:0]           in_valid = '0;
  logic [NumPorts*DataSize-1:0]  in_data = '0;
  logic [NumPorts-1:0]           in_ready;
  logic [NumPorts-1:0]           in_last = '1;
  logic                          buf_valid;
  logic [DataSize-1:0]           buf_data;
  logic                          buf_ready = 1'b1;
  logic [2:0]                    occupancy;

  int compared   = 0;
  int mismatched = 0;

  skid_arbiter #(
    .NUM_PORTS  (NumPorts),
    .DATA_SIZE  (DataSize),
    .FIFO_DEPTH (FifoDepth)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef SKID_ARB_LOCK_EN
    .in_last   (in_last),
`endif
    .buf_valid (buf_valid),
    .buf_data  (buf_data),
    .buf_ready (buf_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later, far from the rising edge
  task automatic applyStimulus(input logic rstN, input logic [3:0] valid,
                               input logic [3:0] last, input logic bufReady);
    @(negedge clk);
    rst_n     = rstN;
    in_valid  = valid;
    in_last   = last;
    buf_ready = bufReady;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < NumPorts; i++) in_data[i*DataSize +: DataSize] = 16'hA000 + 16'(i);

    // Reset with every port requesting: nothing may be granted
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
    checkOutput("reset_buf_valid", 32'(buf_valid), 32'h0);
    checkOutput("reset_occupancy", 32'(occupancy), 32'h0);

    // Free-flowing: 0,1,2,3,0,1 with occupancy pinned at 0; leaves ptr=2
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1);
      checkOutput($sformatf("flow_grant_%0d", k), 32'(in_ready), 32'(1) << (k % 4));
      checkOutput($sformatf("flow_data_%0d", k), 32'(buf_data), 32'hA000 + 32'(k % 4));
      checkOutput($sformatf("flow_occ_%0d", k), 32'(occupancy), 32'h0);
    end

    // Stalled consumer: exactly five grants (2,3,0,1,2) then stop; leaves ptr=3
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
      checkOutput($sformatf("fill_grant_%0d", k), 32'(in_ready), 32'(1) << ((2 + k) % 4));
      checkOutput($sformatf("fill_occ_%0d", k), 32'(occupancy), 32'(k));
    end
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
    checkOutput("full_occ", 32'(occupancy), 32'd5);
    checkOutput("full_in_ready", 32'(in_ready), 32'h0);
    checkOutput("full_buf_valid", 32'(buf_valid), 32'h0);

    // One drain pulse: no grant that cycle, one grant (port 3) the next
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1);
    checkOutput("drain_same_cycle", 32'(in_ready), 32'h0);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
    checkOutput("drain_occ", 32'(occupancy), 32'd4);
    checkOutput("drain_regrant", 32'(in_ready), 32'b1000);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
    checkOutput("refull_occ", 32'(occupancy), 32'd5);
    checkOutput("refull_in_ready", 32'(in_ready), 32'h0);

    // Empty the buffer, then one extra cycle to confirm the count floors at 0
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1);
      checkOutput($sformatf("empty_occ_%0d", k), 32'(occupancy), 32'(5 - k));
    end
    applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1);
    checkOutput("empty_occ_zero", 32'(occupancy), 32'h0);
    applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1);
    checkOutput("empty_occ_floor", 32'(occupancy), 32'h0);

    // ptr=0, only port 2: grant 2 (ptr->3); again only port 2 wraps to 2; then port 3 next
    applyStimulus(1'b1, 4'b0100, 4'b1111, 1'b1);
    checkOutput("single_p2_a", 32'(in_ready), 32'b0100);
    applyStimulus(1'b1, 4'b0100, 4'b1111, 1'b1);
    checkOutput("wrap_p2", 32'(in_ready), 32'b0100);
    checkOutput("wrap_p2_data", 32'(buf_data), 32'hA002);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1);
    checkOutput("after_wrap_p3", 32'(in_ready), 32'b1000);

    // Send with buf_ready while non-empty leaves the count unchanged; leaves ptr=3
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
    checkOutput("hold_grant_0", 32'(in_ready), 32'b0001);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0);
    checkOutput("hold_grant_1", 32'(in_ready), 32'b0010);
    checkOutput("hold_occ_1", 32'(occupancy), 32'd1);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1);
    checkOutput("shift_grant", 32'(in_ready), 32'b0100);
    checkOutput("shift_occ_pre", 32'(occupancy), 32'd2);
    applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b0);
    checkOutput("shift_occ_post", 32'(occupancy), 32'd2);

    // Mid-packet reset at occupancy 3 (port 3 beat has in_last=0 when locking is built)
    applyStimulus(1'b1, 4'b1111, 4'b0111, 1'b0);
    checkOutput("pre_reset_grant", 32'(in_ready), 32'b1000);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
    checkOutput("midreset_occ_pre", 32'(occupancy), 32'd3);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'h0);
    checkOutput("midreset_buf_valid", 32'(buf_valid), 32'h0);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
    checkOutput("midreset_occ_post", 32'(occupancy), 32'h0);
    checkOutput("midreset_in_ready_post", 32'(in_ready), 32'h0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1);
    checkOutput("post_reset_ptr0", 32'(in_ready), 32'b0001);
    checkOutput("post_reset_occ", 32'(occupancy), 32'h0);

`ifdef SKID_ARB_LOCK_EN
    // ptr=1: port 1 sends a 3-beat packet while port 0 waits; afterwards ptr=2 picks port 0
    applyStimulus(1'b1, 4'b0011, 4'b1101, 1'b1);
    checkOutput("lock_beat0", 32'(in_ready), 32'b0010);
    applyStimulus(1'b1, 4'b0001, 4'b1101, 1'b1);
    checkOutput("lock_blocks_p0", 32'(in_ready), 32'h0);
    applyStimulus(1'b1, 4'b0011, 4'b1101, 1'b1);
    checkOutput("lock_beat1", 32'(in_ready), 32'b0010);
    applyStimulus(1'b1, 4'b0011, 4'b1111, 1'b1);
    checkOutput("lock_beat2_last", 32'(in_ready), 32'b0010);
    checkOutput("lock_beat2_data", 32'(buf_data), 32'hA001);
    applyStimulus(1'b1, 4'b0011, 4'b1111, 1'b1);
    checkOutput("unlock_p0", 32'(in_ready), 32'b0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
